// File: rtl/s4_pkg.sv
// Shared types and default widths for the s4 memory-port arbiter.
package s4_pkg;

  localparam int unsigned AW_DEF   = 32;
  localparam int unsigned DW_DEF   = 64;
  localparam int unsigned STARVE_W = 4;
  localparam int unsigned TMO_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    return (&v) ? v : v + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/s4_arb_pick.sv
// Winner select between fetch and load/store, plus the starvation counter
// value to load if this evaluation is taken as an arbitration point.
module s4_arb_pick import s4_pkg::*; #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                if_req_i,
  input  logic                ls_req_i,
  input  logic [STARVE_W-1:0] starve_i,
  output owner_e              win_c_o,
  output logic [STARVE_W-1:0] starve_c_o
);

  logic ls_wins;

  always_comb begin
    ls_wins    = 1'b0;
    starve_c_o = '0;
    if (!(if_req_i && (starve_i >= STARVE_W'(STARVE_MAX)))) begin
      ls_wins = ls_req_i;
    end
    // Only a fetch that is actually waiting and loses builds up starvation.
    if (ls_wins && if_req_i) begin
      starve_c_o = sat_inc(starve_i);
    end
    win_c_o = ls_wins ? OWN_LS : OWN_IF;
  end

endmodule

// File: rtl/s4_mem_arbiter.sv
// Shares the s4 core's single memory port between instruction fetch and the
// load/store unit: one transaction in flight, LS priority, IF anti-starvation.
module s4_mem_arbiter import s4_pkg::*; #(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  output logic            if_err,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_wstrb,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  output logic            ls_err,
  output logic            mem_req,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int unsigned SW = DW / 8;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
  logic [SW-1:0]       mem_wstrb_q, mem_wstrb_d;

  owner_e              win_c;
  logic [STARVE_W-1:0] starve_pick_c;
  logic                resp_c, tmo_hit_c, done_c, arb_c, any_req_c;

  s4_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .if_req_i   (if_req),
    .ls_req_i   (ls_req),
    .starve_i   (starve_q),
    .win_c_o    (win_c),
    .starve_c_o (starve_pick_c)
  );

  // Responses outside WAIT are stray and never reach a requester.
  assign any_req_c = if_req || ls_req;
  assign resp_c    = (state_q == WAIT) && mem_rvalid;
  assign tmo_hit_c = (state_q == WAIT) && !mem_rvalid && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign done_c    = resp_c || tmo_hit_c;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    arb_c       = 1'b0;

    case (state_q)
      IDLE:  arb_c = any_req_c;
      ISSUE: begin
        if (mem_ready) begin
          state_d   = WAIT;
          tmo_d     = '0;
          mem_req_d = 1'b0;
        end
      end
      WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (done_c) begin
          state_d = IDLE;
          arb_c   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Completion edge doubles as an arbitration point for back-to-back issue.
    if (arb_c) begin
      starve_d = starve_pick_c;
      if (any_req_c) begin
        state_d   = ISSUE;
        owner_d   = win_c;
        mem_req_d = 1'b1;
        if (win_c == OWN_LS) begin
          mem_we_d    = ls_we;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_we ? ls_wdata : '0;
          mem_wstrb_d = ls_we ? ls_wstrb : '0;
        end else begin
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      starve_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  // Grants and responses pass straight through in the cycle memory acts.
  assign if_gnt    = (state_q == ISSUE) && mem_ready && (owner_q == OWN_IF);
  assign ls_gnt    = (state_q == ISSUE) && mem_ready && (owner_q == OWN_LS);
  assign if_rvalid = done_c && (owner_q == OWN_IF);
  assign ls_rvalid = done_c && (owner_q == OWN_LS);
  assign if_err    = tmo_hit_c && (owner_q == OWN_IF);
  assign ls_err    = tmo_hit_c && (owner_q == OWN_LS);
  assign if_rdata  = (resp_c && (owner_q == OWN_IF)) ? mem_rdata : '0;
  assign ls_rdata  = (resp_c && (owner_q == OWN_LS) && !mem_we_q) ? mem_rdata : '0;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_s4_mem_arbiter.sv
// Directed bench for s4_mem_arbiter: per-requester response scoreboards, a
// small memory responder and requester drivers that hold req until gnt.
module tb_s4_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          e;
  } exp_t;

  logic          clock, reset;
  logic          if_req, if_gnt, if_rvalid, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic [SW-1:0] ls_wstrb;
  logic          mem_req, mem_ready, mem_we, mem_rvalid, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [SW-1:0] mem_wstrb;

  int tests, fails, cyc;
  int if_todo, ls_todo, rsp_delay, rsp_cnt, n_rv, n0;
  int if_pres_cyc, mreq_rise_cyc, if_gnt_cyc, ls_gnt_cyc, if_rv_cyc, ls_rv_cyc;
  logic [AW-1:0] if_nxt, ls_nxt;
  logic          ls_we_v, tmo_mode, mem_silent, force_rv, rsp_hit, starve_chk, mreq_prev;
  logic [SW-1:0] ls_wstrb_v, acc_wstrb;
  logic [DW-1:0] ls_wdata_v, rsp_data;
  exp_t          exp_if[$], exp_ls[$];
  logic          gnt_log[$];

  assign mem_rvalid = rsp_hit | force_rv;

  s4_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4), .TIMEOUT(64)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ls_err(ls_err),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    if (a == 32'h0000_0100) return 64'h0000_0013_0000_0093;
    return {~a, a};
  endfunction

  function automatic logic [63:0] log_bits();
    logic [63:0] v;
    v = '0;
    foreach (gnt_log[i]) v = {v[62:0], gnt_log[i]};
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int max);
    int n;
    n = 0;
    while (!(if_todo == 0 && ls_todo == 0 && !if_req && !ls_req &&
             exp_if.size() == 0 && exp_ls.size() == 0 && !busy) && n < max) begin
      @(negedge clock);
      n++;
    end
    check(tag, 64'(n < max), 64'd1);
  endtask

  // Memory: accepts on mem_req&mem_ready, answers rsp_delay cycles later.
  always begin : mem_model
    logic          acc;
    logic [AW-1:0] a;
    @(posedge clock);
    acc = mem_req && mem_ready;
    a   = mem_addr;
    #1;
    rsp_hit   = 1'b0;
    mem_rdata = '0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        rsp_hit   = 1'b1;
        mem_rdata = rsp_data;
      end
    end
    if (acc && !mem_silent) begin
      rsp_cnt  = rsp_delay - 1;
      rsp_data = data_of(a);
    end
  end

  always begin : req_if
    logic g;
    exp_t e;
    @(negedge clock);
    g = if_gnt;
    @(posedge clock);
    #1;
    if (g) if_req = 1'b0;
    if (!reset && !if_req && if_todo > 0) begin
      if_req      = 1'b1;
      if_addr     = if_nxt;
      e.d         = data_of(if_nxt);
      e.e         = 1'b0;
      exp_if.push_back(e);
      if_nxt      = if_nxt + 32'd4;
      if_todo--;
      if_pres_cyc = cyc;
    end
  end

  always begin : req_ls
    logic g;
    exp_t e;
    @(negedge clock);
    g = ls_gnt;
    @(posedge clock);
    #1;
    if (g) ls_req = 1'b0;
    if (!reset && !ls_req && ls_todo > 0) begin
      ls_req   = 1'b1;
      ls_we    = ls_we_v;
      ls_addr  = ls_nxt;
      ls_wdata = ls_wdata_v;
      ls_wstrb = ls_wstrb_v;
      e.d      = (ls_we_v || tmo_mode) ? 64'h0 : data_of(ls_nxt);
      e.e      = tmo_mode;
      exp_ls.push_back(e);
      ls_nxt   = ls_nxt + 32'd8;
      ls_todo--;
    end
  end

  always begin : monitor
    exp_t e;
    @(negedge clock);
    check("gnt_excl", 64'(if_gnt & ls_gnt), 64'd0);
    check("rv_excl", 64'(if_rvalid & ls_rvalid), 64'd0);
    if (!if_rvalid) check("if_quiet", 64'((|if_rdata) | if_err), 64'd0);
    if (!ls_rvalid) check("ls_quiet", 64'((|ls_rdata) | ls_err), 64'd0);
    if (mem_req && !mreq_prev) mreq_rise_cyc = cyc;
    mreq_prev = mem_req;
    if (mem_req && mem_ready) acc_wstrb = mem_wstrb;
    if (if_gnt) begin
      if_gnt_cyc = cyc;
      gnt_log.push_back(1'b0);
      if (starve_chk) check("starve_clr", 64'(dut.starve_q), 64'd0);
    end
    if (ls_gnt) begin
      ls_gnt_cyc = cyc;
      gnt_log.push_back(1'b1);
    end
    if (if_rvalid) begin
      n_rv++;
      if_rv_cyc = cyc;
      check("if_rv_pending", 64'(exp_if.size() != 0), 64'd1);
      if (exp_if.size() != 0) begin
        e = exp_if.pop_front();
        check("if_rdata", if_rdata, e.d);
        check("if_err", 64'(if_err), 64'(e.e));
      end
    end
    if (ls_rvalid) begin
      n_rv++;
      ls_rv_cyc = cyc;
      check("ls_rv_pending", 64'(exp_ls.size() != 0), 64'd1);
      if (exp_ls.size() != 0) begin
        e = exp_ls.pop_front();
        check("ls_rdata", ls_rdata, e.d);
        check("ls_err", 64'(ls_err), 64'(e.e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tests = 0; fails = 0; cyc = 0; n_rv = 0; rsp_cnt = 0; rsp_delay = 2;
    reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; if_addr = '0; ls_addr = '0;
    ls_we = 1'b0; ls_wdata = '0; ls_wstrb = '0; mem_ready = 1'b1;
    force_rv = 1'b0; rsp_hit = 1'b0; mem_rdata = '0; mem_silent = 1'b0;
    tmo_mode = 1'b0; starve_chk = 1'b0; mreq_prev = 1'b0;
    ls_we_v = 1'b0; ls_wstrb_v = 8'hFF; ls_wdata_v = 64'h1111_2222_3333_4444;
    if_todo = 0; ls_todo = 0; if_nxt = '0; ls_nxt = '0; acc_wstrb = '1;

    repeat (2) @(negedge clock);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gnt", 64'({if_gnt, ls_gnt}), 64'd0);
    check("rst_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // single fetch with fixed latencies
    if_nxt = 32'h0000_0100; if_todo = 1;
    wait_done("t1_done", 50);
    check("t1_mreq_lat", 64'(mreq_rise_cyc - if_pres_cyc), 64'd1);
    check("t1_gnt_lat", 64'(if_gnt_cyc - if_pres_cyc), 64'd1);
    check("t1_rv_lat", 64'(if_rv_cyc - if_gnt_cyc), 64'd2);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_rd_wstrb", 64'(acc_wstrb), 64'd0);

    // simultaneous requests: LS first, IF back-to-back
    gnt_log.delete();
    if_nxt = 32'h0000_0180; ls_nxt = 32'h8000_0000; if_todo = 1; ls_todo = 1;
    wait_done("t2_done", 50);
    check("t2_len", 64'(gnt_log.size()), 64'd2);
    check("t2_order", log_bits(), 64'h2);
    check("t2_b2b", 64'(if_gnt_cyc - ls_rv_cyc), 64'd1);
    check("t2_ld_wstrb", 64'(acc_wstrb), 64'd0);

    // starvation: four LS wins, then IF, then LS again
    gnt_log.delete(); starve_chk = 1'b1;
    if_nxt = 32'h0000_0200; ls_nxt = 32'h8000_1000; if_todo = 1; ls_todo = 6;
    wait_done("t3_done", 200);
    starve_chk = 1'b0;
    check("t3_len", 64'(gnt_log.size()), 64'd7);
    check("t3_order", log_bits(), 64'h7B);

    // store held in ISSUE by mem_ready=0
    mem_ready = 1'b0; ls_we_v = 1'b1; ls_wstrb_v = 8'h0F;
    ls_wdata_v = 64'hDEAD_BEEF_CAFE_F00D; ls_nxt = 32'h8000_2000; ls_todo = 1;
    repeat (4) @(negedge clock);
    check("t4_req_hold", 64'(mem_req), 64'd1);
    check("t4_no_gnt", 64'(ls_gnt), 64'd0);
    check("t4_we", 64'(mem_we), 64'd1);
    check("t4_wstrb", 64'(mem_wstrb), 64'h0F);
    check("t4_wdata", mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
    check("t4_addr", 64'(mem_addr), 64'h8000_2000);
    @(posedge clock);
    #1 mem_ready = 1'b1;
    wait_done("t4_done", 50);
    ls_we_v = 1'b0; ls_wstrb_v = 8'hFF;

    // timeout, then a late response that must be dropped
    mem_silent = 1'b1; tmo_mode = 1'b1; ls_nxt = 32'h8000_0040; ls_todo = 1;
    wait_done("t5_done", 200);
    check("t5_tmo_lat", 64'(ls_rv_cyc - ls_gnt_cyc), 64'd64);
    mem_silent = 1'b0; tmo_mode = 1'b0;
    n0 = n_rv;
    repeat (2) @(posedge clock);
    #1 force_rv = 1'b1;
    @(posedge clock);
    #1 force_rv = 1'b0;
    repeat (3) @(negedge clock);
    check("t5_late_ignored", 64'(n_rv), 64'(n0));

    // asynchronous reset one cycle into WAIT
    rsp_delay = 6; if_nxt = 32'h0000_0280; if_todo = 1;
    n = 0;
    while (!if_gnt && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("t6_gnt_seen", 64'(if_gnt), 64'd1);
    @(posedge clock);
    #3;
    check("t6_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("t6_mem_req", 64'(mem_req), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_gnt", 64'({if_gnt, ls_gnt}), 64'd0);
    check("t6_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
    exp_if.delete();
    rsp_delay = 2;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    n0 = n_rv;
    repeat (8) @(negedge clock);
    check("t6_stray_ignored", 64'(n_rv), 64'(n0));
    if_nxt = 32'h0000_0300; if_todo = 1;
    wait_done("t6_done", 50);
    check("t6_serviced", 64'(n_rv), 64'(n0 + 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/s4_mem_arbiter.md
Name: s4_mem_arbiter

Overview:
- Shares the single memory port of the s4 RV64I core between two requesters: instruction fetch (IF) and load/store unit (LS).
- One outstanding transaction at a time.
- LS has fixed priority; a starvation counter guarantees IF forward progress.
- A response timeout keeps the core from hanging on a dead memory and drives the PASS/FAIL bench to a clean error.

Parameters:
- AW, 32, address width in bits.
- DW, 64, data width in bits; DW/8 byte strobes.
- STARVE_MAX, 4, consecutive lost arbitrations after which IF wins (1..15).
- TIMEOUT, 64, cycles waited in WAIT before an error response (2..255).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  one-cycle pulse: fetch accepted by memory
- if_rvalid  out  1  one-cycle pulse: fetch data valid
- if_rdata  out  DW  fetch data
- if_err  out  1  qualifies if_rvalid: timeout
- ls_req  in  1  load/store request; held with all ls_* until ls_gnt
- ls_we  in  1  1 = store
- ls_addr  in  AW  load/store address
- ls_wdata  in  DW  store data
- ls_wstrb  in  DW/8  store byte enables
- ls_gnt  out  1  one-cycle pulse: LS accepted by memory
- ls_rvalid  out  1  one-cycle pulse: load data valid / store acknowledged
- ls_rdata  out  DW  load data; 0 for stores
- ls_err  out  1  qualifies ls_rvalid: timeout
- mem_req  out  1  request to memory; held until mem_ready
- mem_ready  in  1  memory accepts request this cycle
- mem_we  out  1  write enable
- mem_addr  out  AW  address
- mem_wdata  out  DW  write data
- mem_wstrb  out  DW/8  byte enables; 0 on reads
- mem_rvalid  in  1  response/ack from memory, one cycle
- mem_rdata  in  DW  read data
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, owner=IF, starve=0, tmo=0, all outputs 0. Async assertion mid-transaction aborts it: mem_req drops immediately and no rvalid is issued.
- States:
  - IDLE: if any req, arbitrate, latch owner and request fields into mem_* registers, go to ISSUE. mem_req rises the cycle after req is seen (1-cycle latency).
  - ISSUE: mem_req=1, mem_* stable. On mem_ready: pulse owner's gnt in the same cycle, drop mem_req next cycle, go to WAIT, tmo=0.
  - WAIT: tmo increments each cycle.
    - On mem_rvalid: pulse owner's rvalid with rdata=mem_rdata (stores: rdata=0), err=0.
    - At the same edge, if any req is pending, arbitrate and go to ISSUE (back-to-back, no IDLE bubble); otherwise go to IDLE.
    - If tmo reaches TIMEOUT-1 without mem_rvalid: pulse rvalid with err=1, rdata=0, then same next-state rule. A late mem_rvalid after timeout is ignored.
- Arbitration, evaluated only at an arbitration point:
  - If starve>=STARVE_MAX and if_req: IF wins.
  - Else if ls_req: LS wins.
  - Else: IF wins.
- Starvation counter:
  - starve increments (saturating at 15) when IF loses with if_req=1.
  - Clears when IF is granted, or at an arbitration point with if_req=0.
- Output exclusivity: at most one of if_gnt/ls_gnt and at most one of if_rvalid/ls_rvalid per cycle. rdata/err are 0 when their rvalid is 0.
- mem_rvalid in IDLE or ISSUE is a protocol violation: ignored and routed to neither port.
- Requester dropping req before gnt: transaction still completes to memory; the response is still pulsed to the owner.
- Writes: mem_rvalid is the acknowledge; rdata is ignored.

Decomposition:
- Shared package s4_pkg: state enum (IDLE, ISSUE, WAIT), owner encoding (OWN_IF=0, OWN_LS=1), default AW/DW constants.
- Sub-module s4_arb_pick: combinational winner select plus saturating starve-counter next-value logic. FSM, timeout counter and mem_* registers stay in the top.

Test Plan:
- Single fetch, addr 0x0000_0100, mem_ready held 1, mem_rvalid 2 cycles after accept with rdata 0x0000_0013_0000_0093 -> mem_req 1 cycle after if_req; if_gnt 1 pulse; if_rvalid 1 pulse with that rdata, if_err=0; busy back to 0.
- if_req and ls_req (load, 0x8000_0000) asserted together in IDLE -> LS issued first, IF issued back-to-back on the LS response edge; no IDLE cycle between them.
- ls_req held continuously, if_req held, STARVE_MAX=4 -> exactly 4 LS grants, then 1 IF grant, then LS again; starve reads 0 after the IF grant.
- Store ls_we=1, wstrb=0x0F, wdata=0xDEAD_BEEF_CAFE_F00D -> mem_wstrb=0x0F, mem_we=1; ls_rvalid pulse with ls_rdata=0.
- No mem_rvalid, TIMEOUT=64 -> ls_rvalid with ls_err=1 exactly 64 cycles after ls_gnt; a mem_rvalid injected 3 cycles later produces no pulse.
- reset asserted 1 cycle into WAIT -> mem_req, busy and all gnt/rvalid go 0 asynchronously; a subsequent stray mem_rvalid is ignored; the next if_req is serviced normally.
